sig_change_monitor: RTL and testbench

Synthesisable, multi-channel value-change monitor: the hardware successor to the simulation-only net monitor used in our mux benches. It watches NCH probe channels of W bits each, detects value changes per clock, tags each with channel index and timestamp, and queues records in an internal FIFO drained through a valid/ready port. It sits beside the unit under observation, in silicon or on an emulation bench, with probes wired to internal nets such as a mux's select-inverse and AND-gate outputs.

---
 rtl/sig_change_monitor.sv | 198 +++++++++++++++++++
 tb/tb_sig_change_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sig_change_monitor.sv
// Multi-channel value-change monitor: timestamps per-channel probe changes and queues
// {channel, value, time} records in a show-ahead FIFO. Optional macro: MON_INITIAL_SNAP_EN.
module sig_change_monitor #(
  parameter  int NCH   = 4,
  parameter  int W     = 1,
  parameter  int DEPTH = 8,
  parameter  int TSW   = 16,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int NW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [NCH*W-1:0] probe,
  input  logic [NCH-1:0]   mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_chan,
  output logic [W-1:0]     out_value,
  output logic [TSW-1:0]   out_time,
  output logic             lost,
  output logic [NW-1:0]    count
);

`ifdef MON_INITIAL_SNAP_EN
  localparam logic SNAP_EN = 1'b1;
`else
  localparam logic SNAP_EN = 1'b0;
`endif
  localparam logic [NW-1:0] FULL_CNT = NW'(DEPTH);

  logic [TSW-1:0]   timer_r;
  logic [NCH*W-1:0] prev_r;
  logic             enable_q_r;
  logic [NCH-1:0]   pend_r;
  logic [W-1:0]     pend_val_r  [NCH];
  logic [TSW-1:0]   pend_time_r [NCH];
  logic             lost_r;

  logic [CW-1:0]    mem_chan_r [DEPTH];
  logic [W-1:0]     mem_val_r  [DEPTH];
  logic [TSW-1:0]   mem_time_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [NW-1:0]    count_r;

  logic             out_valid_r;
  logic [CW-1:0]    out_chan_r;
  logic [W-1:0]     out_value_r;
  logic [TSW-1:0]   out_time_r;

  logic [NCH-1:0]   set_s;
  logic [NCH-1:0]   win_s;
  logic [NCH-1:0]   pend_nxt_s;
  logic             lost_set_s;
  logic [CW-1:0]    sel_s;
  logic             any_pend_s;
  logic             push_s;
  logic             pop_s;
  logic [AW-1:0]    rd_nxt_s;
  logic [NW-1:0]    count_nxt_s;
  logic [CW-1:0]    head_chan_s;
  logic [W-1:0]     head_val_s;
  logic [TSW-1:0]   head_time_s;

  // Change/snapshot detection and lowest-index arbitration over pending channels
  always_comb begin
    set_s      = '0;
    sel_s      = '0;
    any_pend_s = 1'b0;
    for (int c = NCH - 1; c >= 0; c--) begin
      set_s[c]   = enable & ~mask[c] &
                   (enable_q_r ? (probe[c*W +: W] != prev_r[c*W +: W]) : SNAP_EN);
      sel_s      = pend_r[c] ? CW'(c) : sel_s;
      any_pend_s = any_pend_s | pend_r[c];
    end
  end

  assign pop_s  = out_valid_r & out_ready;
  assign push_s = any_pend_s & ((count_r != FULL_CNT) | pop_s);

  // Pending-flag update: a push clears the winner unless it re-changes in the same cycle
  always_comb begin
    win_s      = '0;
    pend_nxt_s = '0;
    lost_set_s = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      win_s[c]      = push_s & (sel_s == CW'(c));
      pend_nxt_s[c] = set_s[c] | (pend_r[c] & ~win_s[c]);
      lost_set_s    = lost_set_s | (set_s[c] & pend_r[c] & ~win_s[c]);
    end
  end

  // Occupancy and next-head selection, so the output registers track the FIFO head
  always_comb begin
    rd_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + NW'(1);
      2'b01:   count_nxt_s = count_r - NW'(1);
      default: count_nxt_s = count_r;
    endcase
    if (count_nxt_s == '0) begin
      head_chan_s = '0;
      head_val_s  = '0;
      head_time_s = '0;
    end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      head_chan_s = sel_s;
      head_val_s  = pend_val_r[sel_s];
      head_time_s = pend_time_r[sel_s];
    end else begin
      head_chan_s = mem_chan_r[rd_nxt_s];
      head_val_s  = mem_val_r[rd_nxt_s];
      head_time_s = mem_time_r[rd_nxt_s];
    end
  end

  // Timer, probe history and per-channel pending records
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_r    <= '0;
      prev_r     <= '0;
      enable_q_r <= 1'b0;
      pend_r     <= '0;
      lost_r     <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        pend_val_r[c]  <= '0;
        pend_time_r[c] <= '0;
      end
    end else begin
      prev_r     <= probe;
      enable_q_r <= enable;
      if (clear) begin
        timer_r <= '0;
        pend_r  <= '0;
        lost_r  <= 1'b0;
      end else begin
        timer_r <= enable ? (timer_r + TSW'(1)) : timer_r;
        pend_r  <= pend_nxt_s;
        lost_r  <= lost_r | lost_set_s;
        for (int c = 0; c < NCH; c++) begin
          if (set_s[c]) begin
            pend_val_r[c]  <= probe[c*W +: W];
            pend_time_r[c] <= timer_r;
          end
        end
      end
    end
  end

  // Record FIFO and registered show-ahead head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_chan_r  <= '0;
      out_value_r <= '0;
      out_time_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_chan_r[i] <= '0;
        mem_val_r[i]  <= '0;
        mem_time_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_chan_r  <= '0;
      out_value_r <= '0;
      out_time_r  <= '0;
    end else begin
      if (push_s) begin
        mem_chan_r[wr_ptr_r] <= sel_s;
        mem_val_r[wr_ptr_r]  <= pend_val_r[sel_s];
        mem_time_r[wr_ptr_r] <= pend_time_r[sel_s];
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != '0);
      out_chan_r  <= head_chan_s;
      out_value_r <= head_val_s;
      out_time_r  <= head_time_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;
  assign out_value = out_value_r;
  assign out_time  = out_time_r;
  assign lost      = lost_r;
  assign count     = count_r;

endmodule

// File: tb/tb_sig_change_monitor.sv
// Scoreboard bench for sig_change_monitor: table-driven change vectors plus hand-written
// backpressure, clear, reset and (with MON_INITIAL_SNAP_EN) snapshot sequences.
module tb_sig_change_monitor;
`ifdef MON_INITIAL_SNAP_EN
  localparam int W = 4;
`else
  localparam int W = 1;
`endif
  localparam int NCH = 4;

  logic             clock = 1'b0;
  logic             reset_n, enable, clear, out_ready;
  logic [NCH*W-1:0] probe;
  logic [NCH-1:0]   mask;
  logic             out_valid, lost;
  logic [1:0]       out_chan;
  logic [W-1:0]     out_value;
  logic [15:0]      out_time;
  logic [3:0]       count;

  sig_change_monitor #(.NCH(NCH), .W(W), .DEPTH(8), .TSW(16)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear(clear),
    .probe(probe), .mask(mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_value(out_value), .out_time(out_time),
    .lost(lost), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [1:0] ch; logic [W-1:0] v; logic [15:0] t; } rec_t;
  typedef struct { logic [3:0] bits; logic [3:0] msk; logic en; logic [3:0] exp_ch; } vec_t;

  rec_t        q[$];
  vec_t        tbl[16];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] tm = 16'd0;
  logic [3:0]  cur = 4'b0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] expand(input logic [3:0] b);
    logic [NCH*W-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*W +: W] = W'(b[c]);
    return r;
  endfunction

  task automatic exp_rec(input int c, input logic [W-1:0] v, input logic [15:0] t);
    rec_t r;
    r.ch = 2'(c);
    r.v  = v;
    r.t  = t;
    q.push_back(r);
  endtask

  // One clock: the timer model follows the edge, inputs may change 1 time unit later
  task automatic cyc();
    @(posedge clock);
    if (clear) tm = 16'd0;
    else if (enable) tm = tm + 16'd1;
    #1;
  endtask

  task automatic toggle(input int c, input bit expect_rec);
    cur[c] = ~cur[c];
    probe  = expand(cur);
    if (expect_rec) exp_rec(c, W'(cur[c]), tm);
    cyc();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      cyc();
      n++;
    end
    chk({name, "_drained"}, q.size(), 32'd0);
  endtask

  // Scoreboard: compare the head on every accepted handshake
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_record: got chan %0d value %0h time %0d, expected none",
                 out_chan, out_value, out_time);
      end else begin
        rec_t r;
        r = q.pop_front();
        chk("rec_chan", 32'(out_chan), 32'(r.ch));
        chk("rec_value", 32'(out_value), 32'(r.v));
        chk("rec_time", 32'(out_time), 32'(r.t));
      end
    end
  end

  initial begin
    tbl[0]  = '{4'b1111, 4'b0000, 1'b1, 4'b1101};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
    tbl[4]  = '{4'b1011, 4'b0100, 1'b1, 4'b0000};
    tbl[5]  = '{4'b1111, 4'b0100, 1'b1, 4'b0000};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
    tbl[7]  = '{4'b1110, 4'b0000, 1'b0, 4'b0000};
    tbl[8]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000};
    tbl[10] = '{4'b1111, 4'b1111, 1'b1, 4'b0000};
    tbl[11] = '{4'b0111, 4'b0000, 1'b1, 4'b1000};
    tbl[12] = '{4'b0110, 4'b0000, 1'b1, 4'b0001};
    tbl[13] = '{4'b0111, 4'b0000, 1'b1, 4'b0001};
    tbl[14] = '{4'b0111, 4'b0000, 1'b1, 4'b0000};
    tbl[15] = '{4'b0111, 4'b0000, 1'b1, 4'b0000};

    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; out_ready = 1'b1;
    probe = '0; mask = 4'hF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_lost", 32'(lost), 32'd0);
    chk("rst_head", {out_chan, out_time, 14'(out_value)}, 32'd0);
    reset_n = 1'b1;
    tm = 16'd0;

    // Baseline with every channel masked, so both snapshot builds agree
    enable = 1'b1;
    cyc();
    mask = 4'h0;
    while (tm != 16'd5) cyc();
    toggle(1, 1'b1);
    chk("lat_edge_n", 32'(out_valid), 32'd0);
    cyc();
    chk("lat_edge_n1", 32'(out_valid), 32'd1);
    chk("lat_count", 32'(count), 32'd1);
    chk("lat_time", 32'(out_time), 32'd5);

    while (tm != 16'd10) cyc();
    for (int i = 0; i < 16; i++) begin
      cur    = tbl[i].bits;
      probe  = expand(cur);
      mask   = tbl[i].msk;
      enable = tbl[i].en;
      for (int c = 0; c < NCH; c++)
        if (tbl[i].exp_ch[c]) exp_rec(c, W'(cur[c]), tm);
      cyc();
    end
    wait_drain("table");
    chk("table_lost", 32'(lost), 32'd0);

    // Backpressure: fill 8, hold a 9th pending, overwrite it with a 10th
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) toggle(0, 1'b1);
    repeat (2) cyc();
    chk("bp_count_full", 32'(count), 32'd8);
    chk("bp_lost_before", 32'(lost), 32'd0);
    toggle(0, 1'b0);
    repeat (2) cyc();
    chk("bp_count_hold", 32'(count), 32'd8);
    chk("bp_lost_hold", 32'(lost), 32'd0);
    toggle(0, 1'b1);
    chk("bp_lost_set", 32'(lost), 32'd1);
    out_ready = 1'b1;
    cyc();
    chk("bp_push_pop_full", 32'(count), 32'd8);
    wait_drain("bp");
    chk("bp_lost_sticky", 32'(lost), 32'd1);

    // Clear with 5 records queued: lost, FIFO and timer all reset
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) toggle(1, 1'b0);
    repeat (2) cyc();
    chk("clr_count_before", 32'(count), 32'd5);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_lost", 32'(lost), 32'd0);
    out_ready = 1'b1;
    toggle(2, 1'b1);
    wait_drain("clr");

    // Asynchronous reset between edges
    out_ready = 1'b0;
    toggle(3, 1'b0);
    toggle(0, 1'b0);
    repeat (2) cyc();
    chk("ar_count_before", 32'(count), 32'd2);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_head", {out_chan, out_time, 14'(out_value)}, 32'd0);
    q.delete();
    enable = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    tm = 16'd0;

`ifdef MON_INITIAL_SNAP_EN
    mask  = 4'h0;
    probe = 16'hA5C3;
    repeat (2) cyc();
    exp_rec(0, 4'h3, 16'd0);
    exp_rec(1, 4'hC, 16'd0);
    exp_rec(2, 4'h5, 16'd0);
    exp_rec(3, 4'hA, 16'd0);
    enable    = 1'b1;
    out_ready = 1'b1;
    cyc();
    wait_drain("snap");
`endif

    out_ready = 1'b1;
    repeat (4) cyc();
    chk("final_queue", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
